pipe_hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_match.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// forward-select encodings and the packed layout of a tracked pipeline entry.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Entry layout, LSB first: flags, then wr_addr, rs, rt (each addr_w bits wide).
  localparam int ENT_VALID   = 0;
  localparam int ENT_WE      = 1;
  localparam int ENT_LOAD    = 2;
  localparam int ENT_RS_USED = 3;
  localparam int ENT_RT_USED = 4;
  localparam int ENT_FLAG_W  = 5;

  function automatic int entry_w(input int addr_w);
    return ENT_FLAG_W + 3 * addr_w;
  endfunction

  function automatic int wr_lsb(input int addr_w);
    return ENT_FLAG_W + 0 * addr_w;
  endfunction

  function automatic int rs_lsb(input int addr_w);
    return ENT_FLAG_W + addr_w;
  endfunction

  function automatic int rt_lsb(input int addr_w);
    return ENT_FLAG_W + 2 * addr_w;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against one tracked entry's destination.
// Register 0 never matches since it is hard-wired to zero.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0]          src_addr,
  input  logic                           src_used,
  input  logic [entry_w(REG_ADDR_W)-1:0] entry,
  output logic                           match
);

  localparam int WR_LSB = wr_lsb(REG_ADDR_W);
  localparam int RS_LSB = rs_lsb(REG_ADDR_W);

  logic unused_fields;

  assign match = src_used && (src_addr != '0) && entry[ENT_VALID] && entry[ENT_WE]
              && (src_addr == entry[WR_LSB +: REG_ADDR_W]);

  assign unused_fields = ^{entry[ENT_LOAD], entry[ENT_RS_USED], entry[ENT_RT_USED],
                           entry[entry_w(REG_ADDR_W)-1:RS_LSB]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the five-stage pipeline.
// Define HAZARD_FWD_EN to enable EXE operand forwarding; otherwise every RAW dependency stalls.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  id_we,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  id_is_load,
  input  logic                  id_branch,
  input  logic                  id_redirect,
  input  logic                  ext_stall,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int EW     = entry_w(REG_ADDR_W);
  localparam int RS_LSB = rs_lsb(REG_ADDR_W);
  localparam int RT_LSB = rt_lsb(REG_ADDR_W);
`ifdef HAZARD_FWD_EN
  localparam int N_MATCH = 8;
`else
  localparam int N_MATCH = 4;
`endif

  logic [EW-1:0]         ex_q, mem_q, wb_q, id_entry;
  logic [REG_ADDR_W-1:0] m_addr [N_MATCH];
  logic                  m_used [N_MATCH];
  logic [EW-1:0]         m_ent  [N_MATCH];
  logic [N_MATCH-1:0]    m_hit;
  logic                  haz, id_ex_hit, id_mem_hit;

  assign id_entry = {id_rt, id_rs, id_wr_addr, id_rt_used, id_rs_used,
                     id_is_load, id_we, id_valid};

  // Slots 0-3: ID sources against EX/MEM; slots 4-7: EX sources against MEM/WB.
  always_comb begin
    m_addr[0] = id_rs; m_used[0] = id_rs_used; m_ent[0] = ex_q;
    m_addr[1] = id_rt; m_used[1] = id_rt_used; m_ent[1] = ex_q;
    m_addr[2] = id_rs; m_used[2] = id_rs_used; m_ent[2] = mem_q;
    m_addr[3] = id_rt; m_used[3] = id_rt_used; m_ent[3] = mem_q;
`ifdef HAZARD_FWD_EN
    m_addr[4] = ex_q[RS_LSB +: REG_ADDR_W]; m_used[4] = ex_q[ENT_RS_USED]; m_ent[4] = mem_q;
    m_addr[5] = ex_q[RT_LSB +: REG_ADDR_W]; m_used[5] = ex_q[ENT_RT_USED]; m_ent[5] = mem_q;
    m_addr[6] = ex_q[RS_LSB +: REG_ADDR_W]; m_used[6] = ex_q[ENT_RS_USED]; m_ent[6] = wb_q;
    m_addr[7] = ex_q[RT_LSB +: REG_ADDR_W]; m_used[7] = ex_q[ENT_RT_USED]; m_ent[7] = wb_q;
`endif
  end

  for (genvar g = 0; g < N_MATCH; g++) begin : g_match
    hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
      .src_addr (m_addr[g]),
      .src_used (m_used[g]),
      .entry    (m_ent[g]),
      .match    (m_hit[g])
    );
  end

  assign id_ex_hit  = m_hit[0] | m_hit[1];
  assign id_mem_hit = m_hit[2] | m_hit[3];

`ifdef HAZARD_FWD_EN
  // A load in MEM never forwards; it is picked up from WB one cycle later.
  assign haz = id_valid & ((id_ex_hit & (ex_q[ENT_LOAD] | id_branch))
                         | (id_branch & id_mem_hit & mem_q[ENT_LOAD]));
  assign fwd_a_sel = !ex_q[ENT_VALID]                ? FWD_REG :
                     (m_hit[4] & ~mem_q[ENT_LOAD])   ? FWD_MEM :
                     m_hit[6]                        ? FWD_WB  : FWD_REG;
  assign fwd_b_sel = !ex_q[ENT_VALID]                ? FWD_REG :
                     (m_hit[5] & ~mem_q[ENT_LOAD])   ? FWD_MEM :
                     m_hit[7]                        ? FWD_WB  : FWD_REG;
`else
  logic unused_nofwd;
  assign haz          = id_valid & (id_ex_hit | id_mem_hit);
  assign fwd_a_sel    = FWD_REG;
  assign fwd_b_sel    = FWD_REG;
  assign unused_nofwd = ^{wb_q, id_branch};
`endif

  assign stall_pc    = haz | ext_stall;
  assign stall_if_id = haz | ext_stall;
  assign bubble_ex   = haz & ~ext_stall;
  assign flush_if_id = id_redirect & id_valid & ~haz & ~ext_stall;

  // Entries advance only when the pipeline is not externally frozen; a hazard inserts an empty EX slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else if (!ext_stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (id_valid && !haz) ? id_entry : '0;
      if (haz && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard sequences then random traffic,
// checked against an instruction-level pipeline model (honours HAZARD_FWD_EN).
module tb_pipe_hazard_ctrl;

  localparam int AW    = 5;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic v, we, ld, br, redir, rsu, rtu;
    logic [AW-1:0] wr, rs, rt;
  } instr_t;

  typedef struct {
    int spc, sif, bub, flush, fa, fb, cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs_used, id_rt_used, id_we, id_is_load, id_branch, id_redirect, ext_stall;
  logic [AW-1:0] id_rs, id_rt, id_wr_addr;
  logic stall_pc, stall_if_id, bubble_ex, flush_if_id;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  // Model: the instructions currently in EX (0), MEM (1), WB (2), plus the stall count.
  instr_t pipe [3];
  int     m_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_we(id_we), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .id_branch(id_branch), .id_redirect(id_redirect), .ext_stall(ext_stall),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt)
  );

  function automatic bit depends(logic [AW-1:0] r, logic used, instr_t p);
    return used && r != 0 && p.v && p.we && p.wr == r;
  endfunction

  function automatic bit reads_from(instr_t c, instr_t p);
    return depends(c.rs, c.rsu, p) || depends(c.rt, c.rtu, p);
  endfunction

  function automatic int model_sel(logic [AW-1:0] r, logic used);
`ifdef HAZARD_FWD_EN
    if (!pipe[0].v) return 0;
    if (depends(r, used, pipe[1]) && !pipe[1].ld) return 1;
    if (depends(r, used, pipe[2])) return 2;
`endif
    return 0;
  endfunction

  function automatic bit model_haz(instr_t id);
    if (!id.v) return 0;
`ifdef HAZARD_FWD_EN
    return (reads_from(id, pipe[0]) && (pipe[0].ld || id.br))
        || (reads_from(id, pipe[1]) && pipe[1].ld && id.br);
`else
    return reads_from(id, pipe[0]) || reads_from(id, pipe[1]);
`endif
  endfunction

  function automatic instr_t mk_alu(int wr, int rs, int rt);
    instr_t i = '0;
    i.v = 1; i.we = 1; i.rsu = 1; i.rtu = 1;
    i.wr = AW'(wr); i.rs = AW'(rs); i.rt = AW'(rt);
    return i;
  endfunction

  function automatic instr_t mk_load(int wr, int base);
    instr_t i = '0;
    i.v = 1; i.we = 1; i.ld = 1; i.rsu = 1;
    i.wr = AW'(wr); i.rs = AW'(base);
    return i;
  endfunction

  function automatic instr_t mk_branch(int rs, int rt, bit redir);
    instr_t i = '0;
    i.v = 1; i.br = 1; i.rsu = 1; i.rtu = 1; i.redir = redir;
    i.rs = AW'(rs); i.rt = AW'(rt);
    return i;
  endfunction

  function automatic instr_t mk_nop();
    instr_t i = '0;
    i.v = 1;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.v     = ($urandom_range(0, 9) != 0);
    i.we    = $urandom_range(0, 1) == 1;
    i.ld    = ($urandom_range(0, 2) == 0);
    i.br    = ($urandom_range(0, 4) == 0);
    i.redir = i.br && ($urandom_range(0, 1) == 1);
    i.rsu   = $urandom_range(0, 3) != 0;
    i.rtu   = $urandom_range(0, 1) == 1;
    i.wr    = AW'($urandom_range(0, 3));
    i.rs    = AW'($urandom_range(0, 3));
    i.rt    = AW'($urandom_range(0, 3));
    return i;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // One clock cycle: drive ID/ext/rst, queue the expected response, advance the model.
  task automatic applyStimulus(input instr_t id, input bit ext, input bit rst_in, output bit haz_o);
    exp_t e;
    bit h;
    @(posedge clk);
    #1;
    rst = rst_in; ext_stall = ext;
    id_valid = id.v; id_rs = id.rs; id_rt = id.rt; id_rs_used = id.rsu; id_rt_used = id.rtu;
    id_we = id.we; id_wr_addr = id.wr; id_is_load = id.ld; id_branch = id.br;
    id_redirect = id.redir;
    h       = model_haz(id);
    e.spc   = int'(h || ext);
    e.sif   = int'(h || ext);
    e.bub   = int'(h && !ext);
    e.flush = int'(id.redir && id.v && !h && !ext);
    e.fa    = model_sel(pipe[0].rs, pipe[0].rsu);
    e.fb    = model_sel(pipe[0].rt, pipe[0].rtu);
    e.cnt   = m_cnt;
    sb.push_back(e);
    if (rst_in) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0; m_cnt = 0;
    end else if (!ext) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (id.v && !h) ? id : '0;
      if (h && m_cnt < CMAX) m_cnt++;
    end
    haz_o = h;
  endtask

  // Present an instruction in ID until it is accepted (no hazard), bounded.
  task automatic issue(input instr_t id);
    bit h;
    int tries = 0;
    do begin
      applyStimulus(id, 1'b0, 1'b0, h);
      tries++;
    end while (h && tries < 8);
    if (h) checkOutput("issue_timeout", tries, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("stall_pc",    int'(stall_pc),    e.spc);
      checkOutput("stall_if_id", int'(stall_if_id), e.sif);
      checkOutput("bubble_ex",   int'(bubble_ex),   e.bub);
      checkOutput("flush_if_id", int'(flush_if_id), e.flush);
      checkOutput("fwd_a_sel",   int'(fwd_a_sel),   e.fa);
      checkOutput("fwd_b_sel",   int'(fwd_b_sel),   e.fb);
      checkOutput("stall_cnt",   int'(stall_cnt),   e.cnt);
    end
  end

  initial begin
    bit h;
    rst = 1'b1; ext_stall = 1'b0;
    id_valid = 0; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
    id_we = 0; id_wr_addr = '0; id_is_load = 0; id_branch = 0; id_redirect = 0;
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0; m_cnt = 0;
    repeat (2) @(posedge clk);
    $display("[TB] reset released, directed sequences");

    // Load-use, then back-to-back ALU forwarding.
    issue(mk_load(2, 1));
    issue(mk_alu(3, 2, 4));
    issue(mk_alu(5, 1, 1));
    issue(mk_alu(6, 5, 5));
    issue(mk_nop());
    // WB forwarding across a nop, and r0 never forwards or stalls.
    issue(mk_alu(7, 1, 1));
    issue(mk_nop());
    issue(mk_alu(8, 0, 7));
    issue(mk_alu(0, 1, 1));
    issue(mk_alu(10, 0, 0));
    issue(mk_nop());
    // Branch after load with a redirect held through the stall.
    issue(mk_load(9, 1));
    issue(mk_branch(9, 0, 1'b1));
    issue(mk_nop());
    issue(mk_nop());
    // External freeze over a pending load-use, then a reset pulse mid-sequence.
    issue(mk_load(2, 1));
    repeat (3) applyStimulus(mk_alu(3, 2, 2), 1'b1, 1'b0, h);
    issue(mk_alu(3, 2, 2));
    issue(mk_load(4, 1));
    applyStimulus(mk_alu(5, 4, 4), 1'b0, 1'b1, h);
    applyStimulus(mk_alu(5, 4, 4), 1'b1, 1'b0, h);
    issue(mk_alu(5, 4, 4));
    repeat (3) issue(mk_nop());

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0), h);
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checkOutput("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
